simon_block_cipher: RTL and testbench

- Parametrised SIMON block-cipher engine covering every SIMON 2n/mn variant from 32/64 to 128/256 through parameters.
- Expands a master key once into an internal round-key store, then encrypts or decrypts any number of blocks against it, one round per clock.
- Ready/valid handshakes on the key, data-in and data-out channels; encrypt/decrypt is selected per block.
- Sits between the host bus adapter and the cipher-mode wrapper.

---
 rtl/simon_pkg.sv | 77 +++++++
 rtl/simon_keystore.sv | 65 ++++++
 rtl/simon_block_cipher.sv | 148 ++++++++++++++
 tb/tb_simon_block_cipher.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared constants, rotation helpers and FSM state type for the SIMON cipher engine.
// Helpers operate on 64-bit containers; callers pass the live word width N.
package simon_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_KEXP  = 2'd1,
        S_ROUND = 2'd2,
        S_HOLD  = 2'd3
    } simon_state_e;

    // Bit 61 holds the first element of each z sequence.
    localparam logic [61:0] Z_SEQ [5] = '{
        62'b11111010001001010110000111001101111101000100101011000011100110,
        62'b10001110111110010011000010110101000111011111001001100001011010,
        62'b10101111011100000011010010011000101000010001111110010110110011,
        62'b11011011101011000110010111100000010010001010011100110100001111,
        62'b11010001111001101011011000100000010111000011001010010011101111
    };

    typedef struct packed {
        int n;
        int m;
        int t;
        int j;
    } simon_cfg_t;

    localparam simon_cfg_t SIMON_CFGS [10] = '{
        '{n: 16, m: 4, t: 32, j: 0},
        '{n: 24, m: 3, t: 36, j: 0},
        '{n: 24, m: 4, t: 36, j: 1},
        '{n: 32, m: 3, t: 42, j: 2},
        '{n: 32, m: 4, t: 44, j: 3},
        '{n: 48, m: 2, t: 52, j: 2},
        '{n: 48, m: 3, t: 54, j: 3},
        '{n: 64, m: 2, t: 68, j: 2},
        '{n: 64, m: 3, t: 69, j: 3},
        '{n: 64, m: 4, t: 72, j: 4}
    };

    function automatic bit simon_cfg_legal(input int n, input int m, input int t, input int j);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (SIMON_CFGS[c].n == n && SIMON_CFGS[c].m == m &&
                SIMON_CFGS[c].t == t && SIMON_CFGS[c].j == j) begin
                ok = 1'b1;
            end
        end
        return ok;
    endfunction

    function automatic logic [63:0] width_mask(input int unsigned n);
        return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    endfunction

    function automatic logic [63:0] rol(input logic [63:0] v, input int unsigned amt,
                                       input int unsigned n);
        logic [63:0] vm;
        vm = v & width_mask(n);
        if (amt == 0) return vm;
        return ((vm << amt) | (vm >> (n - amt))) & width_mask(n);
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] v, input int unsigned amt,
                                       input int unsigned n);
        logic [63:0] vm;
        vm = v & width_mask(n);
        if (amt == 0) return vm;
        return ((vm >> amt) | (vm << (n - amt))) & width_mask(n);
    endfunction

    function automatic logic [63:0] simon_f(input logic [63:0] x, input int unsigned n);
        return (rol(x, 1, n) & rol(x, 8, n)) ^ rol(x, 2, n);
    endfunction

endpackage

// File: rtl/simon_keystore.sv
// Round-key register file: loaded with the master key, extended one word per cycle,
// and read by round index (reversed for decryption).
module simon_keystore
    import simon_pkg::*;
#(
    parameter int N  = 16,
    parameter int M  = 4,
    parameter int T  = 32,
    parameter int J  = 0,
    parameter int CB = $clog2(T)
) (
    input  logic                  clk,
    input  logic                  load_i,
    input  logic [M-1:0][N-1:0]   key_i,
    input  logic                  gen_i,
    input  logic [CB-1:0]         wr_idx_i,
    input  logic [CB-1:0]         rd_idx_i,
    input  logic                  dec_i,
    output logic [N-1:0]          rk_o
);

    logic [N-1:0]  rk_q [T];
    logic [N-1:0]  tmp;
    logic [N-1:0]  rk_new;
    logic [CB-1:0] idx_m1;
    logic [CB-1:0] idx_m3;
    logic [CB-1:0] idx_mm;
    logic [CB-1:0] rd_idx;
    logic [6:0]    zoff;
    logic [5:0]    zpos;
    logic          zbit;

    function automatic logic [N-1:0] rotr(input logic [N-1:0] v, input int unsigned a);
        return N'(ror(64'(v), a, N));
    endfunction

    always_comb begin
        idx_m1 = wr_idx_i - CB'(1);
        idx_m3 = wr_idx_i - CB'(3);
        idx_mm = wr_idx_i - CB'(M);
        tmp    = rotr(rk_q[idx_m1], 3);
        if (M == 4) tmp = tmp ^ rk_q[idx_m3];
        tmp    = tmp ^ rotr(tmp, 1);
        // T-M can exceed the 62-entry z period for the widest variants.
        zoff   = 7'(wr_idx_i) - 7'(M);
        if (zoff >= 7'd62) zoff = zoff - 7'd62;
        zpos   = 6'(7'd61 - zoff);
        zbit   = Z_SEQ[J][zpos];
        rk_new = ~rk_q[idx_mm] ^ tmp ^ N'(zbit) ^ N'(3);
    end

    always_ff @(posedge clk) begin
        if (load_i) begin
            for (int k = 0; k < M; k++) rk_q[k] <= key_i[k];
        end else if (gen_i) begin
            rk_q[wr_idx_i] <= rk_new;
        end
    end

    always_comb begin
        rd_idx = dec_i ? (CB'(T - 1) - rd_idx_i) : rd_idx_i;
        rk_o   = rk_q[rd_idx];
    end

endmodule

// File: rtl/simon_block_cipher.sv
// SIMON 2n/mn engine: one-time key expansion, then one round per clock per block.
// state   | meaning
// S_IDLE  | accepts a key (priority) or, once keys are valid, a block
// S_KEXP  | writes one round key per cycle up to rk[T-1]
// S_ROUND | applies round cnt_q to the block state
// S_HOLD  | presents dout until the consumer takes it
module simon_block_cipher
    import simon_pkg::*;
#(
    parameter int N  = 16,
    parameter int M  = 4,
    parameter int T  = 32,
    parameter int J  = 0,
    parameter int CB = $clog2(T)
) (
    input  logic                  clk,
    input  logic                  nR,
    input  logic                  key_valid,
    output logic                  key_ready,
    input  logic [M-1:0][N-1:0]   key,
    output logic                  key_done,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic [1:0][N-1:0]     din,
    input  logic                  dec,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [1:0][N-1:0]     dout
);

    if (!simon_cfg_legal(N, M, T, J)) begin : g_bad_cfg
        $error("simon_block_cipher: unsupported (N,M,T,J) combination");
    end

    simon_state_e     state_q, state_d;
    logic [CB-1:0]    cnt_q, cnt_d;
    logic [N-1:0]     x_q, x_d;
    logic [N-1:0]     y_q, y_d;
    logic             dec_q, dec_d;
    logic             key_done_q, key_done_d;
    logic [1:0][N-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             ks_load;
    logic             ks_gen;
    logic [N-1:0]     rk;
    logic [N-1:0]     x_new;

    simon_keystore #(.N(N), .M(M), .T(T), .J(J), .CB(CB)) u_keystore (
        .clk      (clk),
        .load_i   (ks_load),
        .key_i    (key),
        .gen_i    (ks_gen),
        .wr_idx_i (cnt_q),
        .rd_idx_i (cnt_q),
        .dec_i    (dec_q),
        .rk_o     (rk)
    );

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            dec_q        <= 1'b0;
            key_done_q   <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            x_q          <= x_d;
            y_q          <= y_d;
            dec_q        <= dec_d;
            key_done_q   <= key_done_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        x_d          = x_q;
        y_d          = y_q;
        dec_d        = dec_q;
        key_done_d   = key_done_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        ks_load      = 1'b0;
        ks_gen       = 1'b0;
        x_new        = y_q ^ N'(simon_f(64'(x_q), N)) ^ rk;

        case (state_q)
            S_IDLE: begin
                if (key_valid) begin
                    ks_load    = 1'b1;
                    key_done_d = 1'b0;
                    cnt_d      = CB'(M);
                    state_d    = S_KEXP;
                end else if (din_valid && key_done_q) begin
                    // Decryption runs the forward round on swapped halves.
                    dec_d   = dec;
                    x_d     = dec ? din[0] : din[1];
                    y_d     = dec ? din[1] : din[0];
                    cnt_d   = '0;
                    state_d = S_ROUND;
                end
            end
            S_KEXP: begin
                ks_gen = 1'b1;
                if (cnt_q == CB'(T - 1)) begin
                    key_done_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CB'(1);
                end
            end
            S_ROUND: begin
                x_d = x_new;
                y_d = x_q;
                if (cnt_q == CB'(T - 1)) begin
                    dout_d       = dec_q ? {x_q, x_new} : {x_new, x_q};
                    dout_valid_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = S_HOLD;
                end else begin
                    cnt_d = cnt_q + CB'(1);
                end
            end
            S_HOLD: begin
                if (dout_ready) begin
                    dout_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign key_ready  = (state_q == S_IDLE);
    assign din_ready  = (state_q == S_IDLE) && key_done_q;
    assign key_done   = key_done_q;
    assign dout_valid = dout_valid_q;
    assign dout       = dout_q;

endmodule

// File: tb/tb_simon_block_cipher.sv
// Scoreboard bench for SIMON 32/64 and 64/128 instances, with an independent reference model.
module tb_simon_block_cipher;

    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [63:0] K_A = 64'h1918_1110_0908_0100;
    localparam logic [127:0] K_B = 128'h1b1a1918_13121110_0b0a0908_03020100;

    logic clk = 1'b0;
    logic nR;
    always #5 clk = ~clk;

    logic              a_key_valid, a_key_ready, a_key_done;
    logic [3:0][15:0]  a_key;
    logic              a_din_valid, a_din_ready, a_dec;
    logic [1:0][15:0]  a_din, a_dout;
    logic              a_dout_valid, a_dout_ready;

    logic              b_key_valid, b_key_ready, b_key_done;
    logic [3:0][31:0]  b_key;
    logic              b_din_valid, b_din_ready, b_dec;
    logic [1:0][31:0]  b_din, b_dout;
    logic              b_dout_valid, b_dout_ready;

    simon_block_cipher u_dut_a (
        .clk(clk), .nR(nR),
        .key_valid(a_key_valid), .key_ready(a_key_ready), .key(a_key), .key_done(a_key_done),
        .din_valid(a_din_valid), .din_ready(a_din_ready), .din(a_din), .dec(a_dec),
        .dout_valid(a_dout_valid), .dout_ready(a_dout_ready), .dout(a_dout)
    );

    simon_block_cipher #(.N(32), .M(4), .T(44), .J(3)) u_dut_b (
        .clk(clk), .nR(nR),
        .key_valid(b_key_valid), .key_ready(b_key_ready), .key(b_key), .key_done(b_key_done),
        .din_valid(b_din_valid), .din_ready(b_din_ready), .din(b_din), .dec(b_dec),
        .dout_valid(b_dout_valid), .dout_ready(b_dout_ready), .dout(b_dout)
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] sb_a [$];
    logic [63:0] sb_b [$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rl16(input logic [15:0] v, input int a);
        return (v << a) | (v >> (16 - a));
    endfunction

    function automatic logic [15:0] rr16(input logic [15:0] v, input int a);
        return (v >> a) | (v << (16 - a));
    endfunction

    function automatic logic [15:0] f16(input logic [15:0] v);
        return (rl16(v, 1) & rl16(v, 8)) ^ rl16(v, 2);
    endfunction

    // Reference SIMON 32/64 with a direct inverse for decryption.
    function automatic logic [31:0] ref_simon(input logic [63:0] k_in, input logic [31:0] blk,
                                              input bit decr);
        logic [15:0] k [32];
        logic [15:0] x, y, t;
        for (int i = 0; i < 4; i++) k[i] = k_in[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            t = rr16(k[i-1], 3) ^ k[i-3];
            t = t ^ rr16(t, 1);
            k[i] = 16'hfffc ^ k[i-4] ^ t ^ {15'b0, Z0[61-(i-4)]};
        end
        x = blk[31:16];
        y = blk[15:0];
        if (!decr) begin
            for (int r = 0; r < 32; r++) begin
                t = x;
                x = y ^ f16(x) ^ k[r];
                y = t;
            end
        end else begin
            for (int r = 31; r >= 0; r--) begin
                t = y;
                y = x ^ f16(y) ^ k[r];
                x = t;
            end
        end
        return {x, y};
    endfunction

    task automatic a_key_load(input logic [63:0] k, input bit with_din);
        int lat, bad;
        @(negedge clk);
        a_key = k;
        a_key_valid = 1'b1;
        a_din_valid = with_din;
        @(negedge clk);
        a_key_valid = 1'b0;
        a_din_valid = 1'b0;
        chk("a_key_done_clr", a_key_done, 0);
        chk("a_din_ready_kexp", a_din_ready, 0);
        lat = 0;
        bad = 0;
        while (!a_key_done && lat < 200) begin
            if (a_din_ready || a_dout_valid) bad++;
            @(negedge clk);
            lat++;
        end
        chk("a_key_lat", lat, 28);
        chk("a_kexp_quiet", bad, 0);
    endtask

    task automatic a_send(input logic [31:0] blk, input bit d, input logic [31:0] exp,
                          input int hold);
        int lat, bad;
        logic [31:0] got;
        lat = 0;
        while (!a_din_ready && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("a_din_ready", a_din_ready, 1);
        a_din = blk;
        a_dec = d;
        a_din_valid = 1'b1;
        sb_a.push_back(exp);
        @(negedge clk);
        a_din_valid = 1'b0;
        a_dec = !d;
        lat = 0;
        while (!a_dout_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("a_out_lat", lat, 32);
        got = a_dout;
        if (sb_a.size() == 0) chk("a_sb_empty", 1, 0);
        else chk("a_dout", got, sb_a.pop_front());
        bad = 0;
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            if (a_dout !== got || !a_dout_valid || a_din_ready || a_key_ready) bad++;
        end
        if (hold > 0) chk("a_hold_stable", bad, 0);
        a_dout_ready = 1'b1;
        @(negedge clk);
        a_dout_ready = 1'b0;
        chk("a_dout_valid_drop", a_dout_valid, 0);
        chk("a_din_ready_back", a_din_ready, 1);
    endtask

    task automatic b_key_load(input logic [127:0] k);
        int lat;
        @(negedge clk);
        b_key = k;
        b_key_valid = 1'b1;
        @(negedge clk);
        b_key_valid = 1'b0;
        lat = 0;
        while (!b_key_done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("b_key_lat", lat, 40);
    endtask

    task automatic b_send(input logic [63:0] blk, input bit d, input logic [63:0] exp);
        int lat;
        chk("b_din_ready", b_din_ready, 1);
        b_din = blk;
        b_dec = d;
        b_din_valid = 1'b1;
        sb_b.push_back(exp);
        @(negedge clk);
        b_din_valid = 1'b0;
        lat = 0;
        while (!b_dout_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("b_out_lat", lat, 44);
        if (sb_b.size() == 0) chk("b_sb_empty", 1, 0);
        else chk("b_dout", b_dout, sb_b.pop_front());
        b_dout_ready = 1'b1;
        @(negedge clk);
        b_dout_ready = 1'b0;
        chk("b_dout_valid_drop", b_dout_valid, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] blk, ct;
        logic [63:0] k2;
        int cnt;
        bit d;

        nR = 1'b0;
        a_key_valid = 0; a_key = '0; a_din_valid = 0; a_din = '0; a_dec = 0; a_dout_ready = 0;
        b_key_valid = 0; b_key = '0; b_din_valid = 0; b_din = '0; b_dec = 0; b_dout_ready = 0;
        #12;
        chk("rst_key_ready", a_key_ready, 1);
        chk("rst_key_done", a_key_done, 0);
        chk("rst_din_ready", a_din_ready, 0);
        chk("rst_dout_valid", a_dout_valid, 0);
        chk("rst_dout", a_dout, 0);
        chk("rst_b_key_done", b_key_done, 0);
        @(negedge clk);
        nR = 1'b1;

        a_key_load(K_A, 1'b0);
        a_send(32'h6565_6877, 1'b0, 32'hc69b_e9bb, 0);
        a_send(32'hc69b_e9bb, 1'b1, 32'h6565_6877, 10);

        b_key_load(K_B);
        b_send(64'h656b696c_20646e75, 1'b0, 64'h44c8fc20_b9dfa07a);
        b_send(64'h44c8fc20_b9dfa07a, 1'b1, 64'h656b696c_20646e75);

        for (int i = 0; i < 4; i++) begin
            blk = $urandom;
            d = 1'($urandom_range(0, 1));
            a_send(blk, d, ref_simon(K_A, blk, d), i);
        end

        // Key and block offered together: key wins, block must be re-sent.
        k2 = {$urandom, $urandom};
        a_din = 32'h1234_5678;
        a_key_load(k2, 1'b1);
        blk = $urandom;
        ct = ref_simon(k2, blk, 1'b0);
        a_send(blk, 1'b0, ct, 0);
        a_send(ct, 1'b1, blk, 2);

        // Reset in the middle of a block.
        @(negedge clk);
        a_din = 32'h6565_6877;
        a_dec = 1'b0;
        a_din_valid = 1'b1;
        @(negedge clk);
        a_din_valid = 1'b0;
        repeat (10) @(negedge clk);
        nR = 1'b0;
        #1;
        chk("mid_rst_key_done", a_key_done, 0);
        chk("mid_rst_dout_valid", a_dout_valid, 0);
        chk("mid_rst_din_ready", a_din_ready, 0);
        @(negedge clk);
        nR = 1'b1;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (a_din_ready || a_dout_valid) cnt++;
        end
        chk("post_rst_idle", cnt, 0);
        chk("post_rst_key_ready", a_key_ready, 1);
        a_key_load(K_A, 1'b0);
        a_send(32'h6565_6877, 1'b0, 32'hc69b_e9bb, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
